// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end controller: turns button pulses into timer commands,
// captures lap times into a small FIFO and counts timer wrap-arounds.
//
// state     | meaning
// ----------+--------------------------------------------
// S_IDLE    | timer reset/stopped, waiting for start
// S_RUNNING | timer counting, laps may be captured
// S_PAUSED  | timer stopped, can resume or be reset
module stopwatch_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int LAP_DEPTH  = 4,
  parameter int WRAP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_ss,
  input  logic                  btn_lr,
  input  logic [DATA_WIDTH-1:0] count,
  output logic                  tmr_start,
  output logic                  tmr_stop,
  output logic                  tmr_reset,
  output logic                  running,
  output logic                  lap_valid,
  output logic [DATA_WIDTH-1:0] lap_data,
  input  logic                  lap_ready,
  output logic                  lap_ovf,
  output logic [WRAP_WIDTH-1:0] wraps
);

  localparam int AW = $clog2(LAP_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [DATA_WIDTH-1:0] MAX_VAL = DATA_WIDTH'(MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_PAUSED} state_t;

  state_t state, state_nxt;
  logic   start_nxt, stop_nxt, reset_nxt, lap_push;

  logic [DATA_WIDTH-1:0] mem [LAP_DEPTH];
  logic [AW:0]           rd_ptr, wr_ptr;
  logic                  fifo_empty, fifo_full, fifo_pop, fifo_push;
  logic [DATA_WIDTH-1:0] count_q;

  // Next-state and command decode; btn_ss has priority over btn_lr.
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    reset_nxt = 1'b0;
    lap_push  = 1'b0;
    case (state)
      S_IDLE: begin
        if (btn_ss) begin
          state_nxt = S_RUNNING;
          start_nxt = 1'b1;
        end
      end
      S_RUNNING: begin
        if (btn_ss) begin
          state_nxt = S_PAUSED;
          stop_nxt  = 1'b1;
        end else if (btn_lr) begin
          lap_push = 1'b1;
        end
      end
      S_PAUSED: begin
        if (btn_ss) begin
          state_nxt = S_RUNNING;
          start_nxt = 1'b1;
        end else if (btn_lr) begin
          state_nxt = S_IDLE;
          reset_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered one-cycle command pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      tmr_start <= 1'b0;
      tmr_stop  <= 1'b0;
      tmr_reset <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr_start <= start_nxt;
      tmr_stop  <= stop_nxt;
      tmr_reset <= reset_nxt;
    end
  end

  assign running = (state == S_RUNNING);

  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign fifo_pop   = !fifo_empty && lap_ready;
  assign fifo_push  = lap_push && (!fifo_full || fifo_pop);

  // FIFO pointers and sticky overflow flag; the flag clears with a timer reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      lap_ovf <= 1'b0;
    end else begin
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (reset_nxt)
        lap_ovf <= 1'b0;
      else if (lap_push && fifo_full && !fifo_pop)
        lap_ovf <= 1'b1;
    end
  end

  // Lap storage; contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr[AW-1:0]] <= count;
  end

  assign lap_valid = !fifo_empty;
  assign lap_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Wrap counting: a MAX->0 transition while running, cleared alongside tmr_reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wraps   <= '0;
    end else begin
      count_q <= count;
      if (reset_nxt)
        wraps <= '0;
      else if (running && count_q == MAX_VAL && count == '0 && wraps != '1)
        wraps <= wraps + WRAP_WIDTH'(1);
    end
  end

endmodule
